// File: rtl/fft_8p_stream_sched.sv
// Streaming scheduler for the 8-point FFT: frame handshake, phase-driven stage enables, output token tracking.
// Optional: define FFT8_BITREV_IDX_EN to emit out_idx in bit-reversed (frequency bin) order.
module fft_8p_stream_sched #(
   parameter int unsigned LATENCY = 11,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_enable,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             en_s2p,
   output logic             en_bf1_1,
   output logic             en_bf1_2,
   output logic             en_bf1_3,
   output logic             en_bf1_4,
   output logic             en_bf2_1,
   output logic             en_bf2_2,
   output logic             en_bf3,
   output logic             out_valid,
   output logic [2:0]       out_idx,
   output logic             out_last,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             busy,
   output logic             err_gap
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              ph_q, ph_d;
   logic [4:0]              drain_q, drain_d;
   logic [LATENCY-1:0]      tv_q, tv_d;
   logic [LATENCY-1:0][2:0] tp_q, tp_d;
   logic                    err_q, err_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic       accept;
   logic       gap;
   logic [2:0] tap_pos;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ph_q    <= '0;
         drain_q <= '0;
         tv_q    <= '0;
         tp_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         drain_q <= drain_d;
         tv_q    <= tv_d;
         tp_q    <= tp_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      drain_d = drain_q;
      tv_d    = {tv_q[LATENCY-2:0], accept};
      tp_d    = {tp_q[LATENCY-2:0], ph_q};
      err_d   = err_q | gap;
      cnt_d   = cnt_q;
      if (out_last) cnt_d = cnt_q + CNT_W'(1);
      // An aborted frame has exactly ph tokens in flight, in the youngest slots.
      for (int unsigned i = 0; i < 7; i++) begin
         if (gap && (i < 32'(ph_q))) tv_d[i+1] = 1'b0;
      end
      unique case (state_q)
         IDLE: begin
            ph_d = '0;
            if (accept) begin
               state_d = STREAM;
               ph_d    = 3'd1;
            end
         end
         STREAM: begin
            ph_d = ph_q + 3'd1;
            if (gap || (ph_q == 3'd0 && !accept)) begin
               state_d = DRAIN;
               drain_d = 5'(LATENCY - 1);
            end
         end
         DRAIN: begin
            ph_d = ph_q + 3'd1;
            if (accept) begin
               state_d = STREAM;
            end else if (drain_q <= 5'd1) begin
               state_d = IDLE;
               ph_d    = '0;
               drain_d = '0;
            end else begin
               drain_d = drain_q - 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      en_bf1_1 = 1'b0;
      en_bf1_2 = 1'b0;
      en_bf1_3 = 1'b0;
      en_bf1_4 = 1'b0;
      en_bf2_1 = 1'b0;
      en_bf2_2 = 1'b0;
      en_bf3   = 1'b0;
      if (!reset) begin
         unique case (state_q)
            IDLE:    in_ready = cfg_enable;
            STREAM:  in_ready = (ph_q != 3'd0) ? 1'b1 : cfg_enable;
            DRAIN:   in_ready = (ph_q == 3'd0) ? cfg_enable : 1'b0;
            default: in_ready = 1'b0;
         endcase
         if (state_q != IDLE) begin
            unique case (ph_q)
               3'd1: en_bf1_4 = 1'b1;
               3'd2: en_bf2_2 = 1'b1;
               3'd3: begin
                  en_bf1_1 = 1'b1;
                  en_bf3   = 1'b1;
               end
               3'd5: en_bf1_2 = 1'b1;
               3'd6: en_bf2_1 = 1'b1;
               3'd7: en_bf1_3 = 1'b1;
               default: ;
            endcase
         end
      end
      accept    = in_valid & in_ready;
      en_s2p    = accept;
      gap       = !reset && state_q == STREAM && ph_q != 3'd0 && !in_valid;
      tap_pos   = tp_q[LATENCY-1];
      out_valid = !reset & tv_q[LATENCY-1];
      out_last  = out_valid & (tap_pos == 3'd7);
`ifdef FFT8_BITREV_IDX_EN
      out_idx   = out_valid ? {tap_pos[0], tap_pos[1], tap_pos[2]} : 3'd0;
`else
      out_idx   = out_valid ? tap_pos : 3'd0;
`endif
      busy      = !reset & ((state_q != IDLE) | (|tv_q));
      err_gap   = err_q;
      frame_cnt = cnt_q;
   end

endmodule

// File: tb/tb_fft_8p_stream_sched.sv
// Directed bench for fft_8p_stream_sched: single-frame vector table plus multi-cycle scenarios.
module tb_fft_8p_stream_sched;

   logic        clk = 1'b0;
   logic        reset, cfg_enable, in_valid;
   logic        in_ready, en_s2p;
   logic        en_bf1_1, en_bf1_2, en_bf1_3, en_bf1_4, en_bf2_1, en_bf2_2, en_bf3;
   logic        out_valid, out_last, busy, err_gap;
   logic [2:0]  out_idx;
   logic [15:0] frame_cnt;
   logic [6:0]  en_all;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign en_all = {en_bf1_1, en_bf1_2, en_bf1_3, en_bf1_4, en_bf2_1, en_bf2_2, en_bf3};

   fft_8p_stream_sched #(.LATENCY(11), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .in_valid(in_valid),
      .in_ready(in_ready), .en_s2p(en_s2p),
      .en_bf1_1(en_bf1_1), .en_bf1_2(en_bf1_2), .en_bf1_3(en_bf1_3), .en_bf1_4(en_bf1_4),
      .en_bf2_1(en_bf2_1), .en_bf2_2(en_bf2_2), .en_bf3(en_bf3),
      .out_valid(out_valid), .out_idx(out_idx), .out_last(out_last),
      .frame_cnt(frame_cnt), .busy(busy), .err_gap(err_gap)
   );

   typedef struct {
      logic        cfg, iv;
      logic        rdy, s2p;
      logic [6:0]  en;
      logic        ov;
      logic [2:0]  pos;
      logic        last, busy;
      logic [15:0] fcnt;
   } vec_t;

   vec_t tbl [21];

   // {bf1_1,bf1_2,bf1_3,bf1_4,bf2_1,bf2_2,bf3} expected for each phase
   function automatic logic [6:0] en_of(input int unsigned ph);
      case (ph)
         1: return 7'b0001000;
         2: return 7'b0000010;
         3: return 7'b1000001;
         5: return 7'b0100000;
         6: return 7'b0000100;
         7: return 7'b0010000;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [2:0] idx_of(input logic [2:0] pos);
`ifdef FFT8_BITREV_IDX_EN
      return {pos[0], pos[1], pos[2]};
`else
      return pos;
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic rst, input logic cfg, input logic iv);
      @(posedge clk);
      #1;
      reset      = rst;
      cfg_enable = cfg;
      in_valid   = iv;
      @(negedge clk);
   endtask

   task automatic check_cyc(input string t, input int c, input logic rdy, input logic s2p,
                            input logic [6:0] en, input logic ov, input logic [2:0] pos,
                            input logic bsy);
      chk($sformatf("%s.rdy[%0d]", t, c), 32'(in_ready), 32'(rdy));
      chk($sformatf("%s.s2p[%0d]", t, c), 32'(en_s2p), 32'(s2p));
      chk($sformatf("%s.en[%0d]", t, c), 32'(en_all), 32'(en));
      chk($sformatf("%s.ov[%0d]", t, c), 32'(out_valid), 32'(ov));
      chk($sformatf("%s.idx[%0d]", t, c), 32'(out_idx), ov ? 32'(idx_of(pos)) : 32'd0);
      chk($sformatf("%s.last[%0d]", t, c), 32'(out_last), 32'(ov && pos == 3'd7));
      chk($sformatf("%s.busy[%0d]", t, c), 32'(busy), 32'(bsy));
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      chk("rst.rdy", 32'(in_ready), 32'd0);
      chk("rst.s2p", 32'(en_s2p), 32'd0);
      chk("rst.en", 32'(en_all), 32'd0);
      chk("rst.ov", 32'(out_valid), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.err", 32'(err_gap), 32'd0);
      chk("rst.fcnt", 32'(frame_cnt), 32'd0);
   endtask

   initial begin
      reset = 1'b1; cfg_enable = 1'b0; in_valid = 1'b0;

      //         cfg   iv    rdy   s2p   en            ov    pos   last  busy  fcnt
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7'b0000000, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7'b0001000, 1'b0, 3'd0, 1'b0, 1'b1, 16'd0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7'b0000010, 1'b0, 3'd0, 1'b0, 1'b1, 16'd0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7'b1000001, 1'b0, 3'd0, 1'b0, 1'b1, 16'd0};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7'b0000000, 1'b0, 3'd0, 1'b0, 1'b1, 16'd0};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7'b0100000, 1'b0, 3'd0, 1'b0, 1'b1, 16'd0};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7'b0000100, 1'b0, 3'd0, 1'b0, 1'b1, 16'd0};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7'b0010000, 1'b0, 3'd0, 1'b0, 1'b1, 16'd0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b0000000, 1'b0, 3'd0, 1'b0, 1'b1, 16'd0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 3'd0, 1'b0, 1'b1, 16'd0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0000010, 1'b0, 3'd0, 1'b0, 1'b1, 16'd0};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b1000001, 1'b1, 3'd0, 1'b0, 1'b1, 16'd0};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1, 3'd1, 1'b0, 1'b1, 16'd0};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0100000, 1'b1, 3'd2, 1'b0, 1'b1, 16'd0};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0000100, 1'b1, 3'd3, 1'b0, 1'b1, 16'd0};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0010000, 1'b1, 3'd4, 1'b0, 1'b1, 16'd0};
      tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b0000000, 1'b1, 3'd5, 1'b0, 1'b1, 16'd0};
      tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b1, 3'd6, 1'b0, 1'b1, 16'd0};
      tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0000010, 1'b1, 3'd7, 1'b1, 1'b1, 16'd0};
      tbl[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b0000000, 1'b0, 3'd0, 1'b0, 1'b0, 16'd1};
      tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b0000000, 1'b0, 3'd0, 1'b0, 1'b0, 16'd1};

      // Single frame from the vector table
      do_reset();
      for (int i = 0; i < 21; i++) begin
         cyc(1'b0, tbl[i].cfg, tbl[i].iv);
         check_cyc("t1", i, tbl[i].rdy, tbl[i].s2p, tbl[i].en, tbl[i].ov, tbl[i].pos, tbl[i].busy);
         chk($sformatf("t1.fcnt[%0d]", i), 32'(frame_cnt), 32'(tbl[i].fcnt));
      end

      // Four frames back-to-back
      do_reset();
      for (int c = 0; c < 50; c++) begin
         cyc(1'b0, 1'b1, c < 32);
         check_cyc("t2", c, (c < 33 || c == 40 || c >= 43), c < 32,
                   (c >= 1 && c <= 42) ? en_of(c % 8) : 7'd0,
                   c >= 11 && c < 43, 3'((c - 11) % 8), c >= 1 && c <= 42);
      end
      chk("t2.fcnt", 32'(frame_cnt), 32'd4);

      // Mid-frame gap at index 5 of frame 2
      do_reset();
      for (int c = 0; c < 30; c++) begin
         cyc(1'b0, 1'b1, c < 13);
         check_cyc("t3", c, (c <= 13 || c == 16 || c >= 24), c < 13,
                   (c >= 1 && c <= 23) ? en_of(c % 8) : 7'd0,
                   c >= 11 && c <= 18, 3'((c - 11) % 8), c >= 1 && c <= 23);
         chk($sformatf("t3.err[%0d]", c), 32'(err_gap), 32'(c >= 14));
      end
      chk("t3.fcnt", 32'(frame_cnt), 32'd1);

      // cfg_enable dropped at sample 3; err_gap must also be cleared by the reset
      do_reset();
      for (int c = 0; c < 25; c++) begin
         cyc(1'b0, c < 3, 1'b1);
         check_cyc("t4", c, c < 8, c < 8,
                   (c >= 1 && c <= 18) ? en_of(c % 8) : 7'd0,
                   c >= 11 && c <= 18, 3'((c - 11) % 8), c >= 1 && c <= 18);
      end
      chk("t4.fcnt", 32'(frame_cnt), 32'd1);
      chk("t4.err", 32'(err_gap), 32'd0);

      // Reset at cycle 14 of a two-frame stream
      do_reset();
      for (int c = 0; c < 40; c++) begin
         cyc(c == 14, c < 15, c < 16);
         check_cyc("t5", c, c < 14, c < 14,
                   (c >= 1 && c <= 13) ? en_of(c % 8) : 7'd0,
                   c >= 11 && c <= 13, 3'((c - 11) % 8), c >= 1 && c <= 13);
         chk($sformatf("t5.fcnt[%0d]", c), 32'(frame_cnt), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
